// File: rtl/prewish5k_btnpoll.sv
// prewish5k_btnpoll
//   Mentor-side button poller. Every POLL_PERIOD idle cycles it issues a
//   one-cycle request strobe to a student, then waits up to TIMEOUT cycles
//   for a one-cycle reply carrying a status byte. Captured bit0 edges
//   produce press/release pulses. A missing reply produces a timeout pulse.
//
// Ports
//   CLK_I      sole clock, rising edge
//   RST_I      asynchronous, active-high reset
//   STB_O      request strobe to student (one cycle per poll)
//   DAT_O      input-select mask to student, constant 8'h01
//   STB_I      student reply strobe
//   DAT_I      student status byte, valid with STB_I
//   o_state    last captured status byte
//   o_press    one-cycle pulse on captured bit0 0->1
//   o_release  one-cycle pulse on captured bit0 1->0
//   o_timeout  one-cycle pulse when a poll gets no reply
//   o_count    press counter
//
// Build option
//   PREWISH5K_PRESS_COUNT_EN  when defined, o_count counts presses (mod 256);
//                             otherwise o_count is tied to 8'h00.
//
// state  | meaning
// IDLE   | poll timer counting down to the next request
// REQ    | STB_O high for this cycle; reply window armed
// WAIT   | waiting for STB_I or for the timeout counter to expire

module prewish5k_btnpoll #(
  parameter int POLL_PERIOD = 100000,
  parameter int POLL_BITS   = 17,
  parameter int TIMEOUT     = 15,
  parameter int TO_BITS     = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_state,
  output logic       o_press,
  output logic       o_release,
  output logic       o_timeout,
  output logic [7:0] o_count
);

  localparam logic [POLL_BITS-1:0] POLL_RELOAD = POLL_BITS'(POLL_PERIOD - 1);
  localparam logic [TO_BITS-1:0]   TO_RELOAD   = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t               state;
  logic [POLL_BITS-1:0] poll_cnt;
  logic [TO_BITS-1:0]   to_cnt;

  assign DAT_O = 8'h01;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= S_IDLE;
      poll_cnt  <= POLL_RELOAD;
      to_cnt    <= '0;
      STB_O     <= 1'b0;
      o_state   <= 8'h00;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_timeout <= 1'b0;
`ifdef PREWISH5K_PRESS_COUNT_EN
      o_count   <= 8'h00;
`endif
    end else begin
      // Pulses and the strobe default low; each is raised for one cycle only.
      STB_O     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (poll_cnt == '0) begin
            state <= S_REQ;
            STB_O <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end
        S_REQ: begin
          to_cnt <= TO_RELOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // A reply wins over expiry, even on the last cycle of the window.
          if (STB_I) begin
            o_state   <= DAT_I;
            o_press   <= DAT_I[0] & ~o_state[0];
            o_release <= ~DAT_I[0] & o_state[0];
`ifdef PREWISH5K_PRESS_COUNT_EN
            if (DAT_I[0] & ~o_state[0])
              o_count <= o_count + 8'd1;
`endif
            poll_cnt  <= POLL_RELOAD;
            state     <= S_IDLE;
          end else if (to_cnt == '0) begin
            o_timeout <= 1'b1;
            poll_cnt  <= POLL_RELOAD;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        default: begin
          poll_cnt <= POLL_RELOAD;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifndef PREWISH5K_PRESS_COUNT_EN
  assign o_count = 8'h00;
`endif

endmodule

// File: tb/tb_prewish5k_btnpoll.sv
// Directed bench for prewish5k_btnpoll with POLL_PERIOD=4, TIMEOUT=3.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_prewish5k_btnpoll;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic [7:0] o_state;
  logic       o_press;
  logic       o_release;
  logic       o_timeout;
  logic [7:0] o_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_cnt = 8'h00;

  prewish5k_btnpoll #(
    .POLL_PERIOD(4),
    .POLL_BITS  (17),
    .TIMEOUT    (3),
    .TO_BITS    (4)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .STB_O    (STB_O),
    .DAT_O    (DAT_O),
    .STB_I    (STB_I),
    .DAT_I    (DAT_I),
    .o_state  (o_state),
    .o_press  (o_press),
    .o_release(o_release),
    .o_timeout(o_timeout),
    .o_count  (o_count)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  function automatic logic [7:0] count_model();
`ifdef PREWISH5K_PRESS_COUNT_EN
    return exp_cnt;
`else
    return 8'h00;
`endif
  endfunction

  // Counts edges until STB_O is seen high, bounded; also checks that the
  // capture/timeout pulses have dropped after their single cycle.
  task automatic wait_stb(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        check({tag, "_press_drop"},   o_press,   1'b0);
        check({tag, "_release_drop"}, o_release, 1'b0);
        check({tag, "_timeout_drop"}, o_timeout, 1'b0);
      end
    end while (!STB_O && n < 40);
    check({tag, "_stb_seen"},    STB_O, 1'b1);
    check({tag, "_stb_spacing"}, n,     exp_n);
  endtask

  // Called with STB_O just observed high. k = edge within WAIT (1..3) at
  // which the reply is sampled; k = 0 means the student stays silent.
  task automatic do_poll(input string tag, input logic [7:0] d, input int k,
                         input logic [7:0] exp_state, input logic exp_press,
                         input logic exp_release);
    tick();
    check({tag, "_stb_one_cycle"}, STB_O, 1'b0);
    if (k == 0) begin
      tick();
      check({tag, "_no_to_early1"}, o_timeout, 1'b0);
      tick();
      check({tag, "_no_to_early2"}, o_timeout, 1'b0);
      tick();
      check({tag, "_timeout"}, o_timeout, 1'b1);
    end else begin
      for (int i = 0; i < k - 1; i++) tick();
      STB_I = 1'b1;
      DAT_I = d;
      tick();
      STB_I = 1'b0;
      check({tag, "_timeout"}, o_timeout, 1'b0);
    end
    if (exp_press) exp_cnt = exp_cnt + 8'd1;
    check({tag, "_state"},   o_state,   exp_state);
    check({tag, "_press"},   o_press,   exp_press);
    check({tag, "_release"}, o_release, exp_release);
    check({tag, "_count"},   o_count,   count_model());
  endtask

  initial begin
    repeat (2) @(posedge CLK_I);
    #1;
    check("rst_stb",     STB_O,     1'b0);
    check("rst_dat_o",   DAT_O,     8'h01);
    check("rst_state",   o_state,   8'h00);
    check("rst_press",   o_press,   1'b0);
    check("rst_release", o_release, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_count",   o_count,   8'h00);
    RST_I = 1'b0;

    wait_stb("first", 4);
    do_poll("p1", 8'h01, 2, 8'h01, 1'b1, 1'b0);
    wait_stb("p1", 4);
    do_poll("p2", 8'h00, 2, 8'h00, 1'b0, 1'b1);
    wait_stb("p2", 4);
    do_poll("p3_silent", 8'h00, 0, 8'h00, 1'b0, 1'b0);
    wait_stb("p3", 4);
    do_poll("p4_last", 8'h01, 3, 8'h01, 1'b1, 1'b0);

    // Strobe while idle must be ignored.
    STB_I = 1'b1;
    DAT_I = 8'hAA;
    tick();
    STB_I = 1'b0;
    check("idle_stb_state", o_state, 8'h01);
    check("idle_stb_press", o_press, 1'b0);
    wait_stb("p4", 3);

    do_poll("p5_early", 8'h03, 1, 8'h03, 1'b0, 1'b0);
    wait_stb("p5", 4);
    do_poll("p6", 8'h02, 2, 8'h02, 1'b0, 1'b1);
    wait_stb("p6", 4);

    // Reset in the middle of WAIT; a late reply after release is ignored.
    tick();
    RST_I = 1'b1;
    #1;
    check("mid_rst_state",   o_state,   8'h00);
    check("mid_rst_stb",     STB_O,     1'b0);
    check("mid_rst_release", o_release, 1'b0);
    check("mid_rst_count",   o_count,   8'h00);
    exp_cnt = 8'h00;
    tick();
    RST_I = 1'b0;
    tick();
    STB_I = 1'b1;
    DAT_I = 8'h01;
    tick();
    STB_I = 1'b0;
    check("late_stb_state",   o_state,   8'h00);
    check("late_stb_press",   o_press,   1'b0);
    check("late_stb_timeout", o_timeout, 1'b0);
    wait_stb("after_rst", 2);

    // 256 press/release rounds: counter wraps back to zero when enabled.
    for (int r = 0; r < 256; r++) begin
      do_poll("wrap_p", 8'h01, 2, 8'h01, 1'b1, 1'b0);
      wait_stb("wrap_p", 4);
      do_poll("wrap_r", 8'h00, 2, 8'h00, 1'b0, 1'b1);
      wait_stb("wrap_r", 4);
    end
    check("wrap_count_final", o_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/prewish5k_btnpoll.md
PREWISH5K_BTNPOLL -- requirements
Module: prewish5k_btnpoll

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 100000, idle cycles between polls (legal range 1..2^POLL_BITS-1).
REQ-002 SHALL have parameter POLL_BITS, default 17, width of poll countdown timer.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waited for a student reply (legal range 1..2^TO_BITS-1).
REQ-004 SHALL have parameter TO_BITS, default 4, width of timeout counter.
REQ-005 SHALL have port CLK_I  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port RST_I  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port STB_O  output  1  mentor request strobe to student.
REQ-008 SHALL have port DAT_O  output  8  input-select mask to student, constant 8'h01.
REQ-009 SHALL have port STB_I  input  1  student reply strobe, one cycle wide.
REQ-010 SHALL have port DAT_I  input  8  student status byte, valid while STB_I=1.
REQ-011 SHALL have port o_state  output  8  last captured status byte.
REQ-012 SHALL have port o_press  output  1  one-cycle pulse on captured bit0 0->1.
REQ-013 SHALL have port o_release  output  1  one-cycle pulse on captured bit0 1->0.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse when a poll gets no reply.
REQ-015 SHALL have port o_count  output  8  press counter (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT; any unused encoding SHALL go to IDLE next cycle with STB_O=0.
REQ-017 IDLE: poll timer counts down from POLL_PERIOD-1; at 0 SHALL move to REQ next cycle.
REQ-018 REQ: STB_O=1 for exactly one cycle; timeout counter loaded with TIMEOUT-1; next state WAIT.
REQ-019 WAIT: STB_O=0; on STB_I=1 SHALL register DAT_I into o_state, reload poll timer, go IDLE.
REQ-020 WAIT without STB_I: counter decrements; when 0 and STB_I=0, SHALL pulse o_timeout one cycle, keep o_state, reload poll timer, go IDLE.
REQ-021 STB_I=1 on the same cycle the timeout counter is 0 SHALL count as a reply; no o_timeout.
REQ-022 STB_I in IDLE or REQ SHALL be ignored; o_state unchanged.
REQ-023 o_press SHALL be registered with the capture: DAT_I[0] & ~o_state[0]; o_release: ~DAT_I[0] & o_state[0]; both 0 otherwise.
REQ-024 o_press and o_release SHALL never be high in the same cycle; neither pulses on timeout.
REQ-025 Poll start spacing SHALL be POLL_PERIOD + 2 + reply-wait cycles (REQ cycle, WAIT cycles, then IDLE).

Reset
REQ-026 RST_I=1 SHALL immediately force: state IDLE, STB_O=0, o_state=0, o_press=0, o_release=0, o_timeout=0, o_count=0, poll timer=POLL_PERIOD-1.
REQ-027 Reset asserted mid-WAIT SHALL abandon the poll; a later STB_I before the next REQ is ignored.
REQ-028 After RST_I falls, first STB_O SHALL occur POLL_PERIOD cycles later.

Configuration
REQ-029 Macro PREWISH5K_PRESS_COUNT_EN defined: o_count SHALL increment by 1 on every o_press, wrapping 255->0.
REQ-030 Macro not defined: o_count SHALL be tied 8'h00 and no counter register synthesized.

Verification (POLL_PERIOD=4, TIMEOUT=3; student model raises STB_I one cycle after STB_O falls)
REQ-031 Reset release, DAT_I=8'h01 -> STB_O high at cycle 4, o_state=8'h01 and o_press=1 for one cycle at cycle 7.
REQ-032 Next poll DAT_I=8'h00 -> o_release one-cycle pulse, o_state=8'h00, o_press stays 0.
REQ-033 Student silent -> o_timeout one-cycle pulse 3 cycles after WAIT entry, o_state held, next STB_O 4 idle cycles later.
REQ-034 STB_I arrives on the final WAIT cycle -> treated as reply, o_timeout stays 0.
REQ-035 RST_I asserted during WAIT, STB_I pulse 1 cycle after release -> ignored, all outputs 0.
REQ-036 With PREWISH5K_PRESS_COUNT_EN, 256 press/release cycles -> o_count returns to 8'h00; without macro o_count always 8'h00.
